// File: rtl/pin_route_matrix_if.sv
// rtl/pin_route_matrix_if.sv - route table configuration and commit bus
interface pin_route_matrix_if #(
    parameter int N_SRC = 36,
    parameter int N_DST = 35,
    parameter int SW    = $clog2(N_SRC),
    parameter int DW    = $clog2(N_DST)
);
    logic          cfg_valid;
    logic          cfg_ready;
    logic [DW-1:0] cfg_dst;
    logic [SW-1:0] cfg_src;
    logic          cfg_en;
    logic          cfg_inv;
    logic          cfg_err;
    logic          commit;
    logic          busy;

    modport master (
        output cfg_valid, cfg_dst, cfg_src, cfg_en, cfg_inv, commit,
        input  cfg_ready, cfg_err, busy
    );

    modport slave (
        input  cfg_valid, cfg_dst, cfg_src, cfg_en, cfg_inv, commit,
        output cfg_ready, cfg_err, busy
    );
endinterface

// File: rtl/pin_route_matrix.sv
// rtl/pin_route_matrix.sv - reconfigurable source-to-destination pin router
// Shadow/active route tables; commits swap them with a break-before-make window.
module pin_route_matrix #(
    parameter int N_SRC       = 36,
    parameter int N_DST       = 35,
    parameter int SYNC_STAGES = 2,
    parameter int BBM_CYCLES  = 4,
    parameter int SW          = $clog2(N_SRC),
    parameter int DW          = $clog2(N_DST)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N_SRC-1:0]   src_in,
    output logic [N_DST-1:0]   dst_out,
    output logic [N_DST-1:0]   dst_oe,
    pin_route_matrix_if.slave  cfg
);
    typedef enum logic [1:0] {IDLE, BBM, APPLY} state_t;

    state_t           state, state_n;
    logic [7:0]       cnt, cnt_n;
    logic [N_SRC-1:0] src_s;
    logic [SW-1:0]    sh_src  [N_DST];
    logic [SW-1:0]    act_src [N_DST];
    logic [N_DST-1:0] sh_en, sh_inv, act_en, act_inv;
    logic             wr_acc, wr_bad, outs_off;

    generate
        if (SYNC_STAGES == 0) begin : g_bypass
            assign src_s = src_in;
        end else begin : g_sync
            logic [N_SRC-1:0] stage [SYNC_STAGES];
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < SYNC_STAGES; i++) stage[i] <= '0;
                end else begin
                    stage[0] <= src_in;
                    for (int i = 1; i < SYNC_STAGES; i++) stage[i] <= stage[i-1];
                end
            end
            assign src_s = stage[SYNC_STAGES-1];
        end
    endgenerate

    assign cfg.cfg_ready = (state == IDLE);
    assign cfg.busy      = (state != IDLE);
    assign outs_off      = (state != IDLE);
    assign wr_acc        = cfg.cfg_valid & cfg.cfg_ready;
    assign wr_bad        = (32'(cfg.cfg_dst) >= 32'(N_DST)) || (32'(cfg.cfg_src) >= 32'(N_SRC));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        case (state)
            IDLE: begin
                if (cfg.commit) begin
                    if (BBM_CYCLES == 0) begin
                        state_n = APPLY;
                    end else begin
                        state_n = BBM;
                        cnt_n   = 8'(BBM_CYCLES);
                    end
                end
            end
            BBM: begin
                if (cnt <= 8'd1) state_n = APPLY;
                else             cnt_n   = cnt - 8'd1;
            end
            APPLY:   state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // A write in the same cycle as commit lands here first, so APPLY picks it up.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int d = 0; d < N_DST; d++) sh_src[d] <= '0;
            sh_en       <= '0;
            sh_inv      <= '0;
            cfg.cfg_err <= 1'b0;
        end else begin
            cfg.cfg_err <= wr_acc & wr_bad;
            if (wr_acc && !wr_bad) begin
                sh_src[cfg.cfg_dst] <= cfg.cfg_src;
                sh_en[cfg.cfg_dst]  <= cfg.cfg_en;
                sh_inv[cfg.cfg_dst] <= cfg.cfg_inv;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int d = 0; d < N_DST; d++) act_src[d] <= '0;
            act_en  <= '0;
            act_inv <= '0;
        end else if (state == APPLY) begin
            act_src <= sh_src;
            act_en  <= sh_en;
            act_inv <= sh_inv;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dst_out <= '0;
            dst_oe  <= '0;
        end else begin
            for (int d = 0; d < N_DST; d++) begin
                dst_oe[d]  <= act_en[d] & ~outs_off;
                dst_out[d] <= (src_s[act_src[d]] ^ act_inv[d]) & act_en[d] & ~outs_off;
            end
        end
    end
endmodule

// File: tb/tb_pin_route_matrix.sv
// tb/tb_pin_route_matrix.sv - directed and randomized checks against a route-table model
module tb_pin_route_matrix;
    localparam int N_SRC = 36;
    localparam int N_DST = 35;
    localparam int SYNC  = 2;
    localparam int BBM   = 4;
    localparam int SW    = $clog2(N_SRC);
    localparam int DW    = $clog2(N_DST);

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic [N_SRC-1:0] src_in = '0;
    logic [N_DST-1:0] dst_out, dst_oe;

    pin_route_matrix_if #(.N_SRC(N_SRC), .N_DST(N_DST)) bus ();

    pin_route_matrix #(.N_SRC(N_SRC), .N_DST(N_DST), .SYNC_STAGES(SYNC), .BBM_CYCLES(BBM)) dut (
        .clk(clk), .rst_n(rst_n), .src_in(src_in),
        .dst_out(dst_out), .dst_oe(dst_oe), .cfg(bus)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;
    bit cmp_on = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Model: route tables as plain arrays, busy as "cycles of commit remaining".
    int               m_sh_src [N_DST];
    bit               m_sh_en  [N_DST];
    bit               m_sh_inv [N_DST];
    int               m_act_src [N_DST];
    bit               m_act_en  [N_DST];
    bit               m_act_inv [N_DST];
    logic [N_SRC-1:0] hist [0:3];
    logic [N_SRC-1:0] sv;
    int               m_left;
    bit               busy_pre;
    logic [N_DST-1:0] e_out, e_oe;
    bit               e_err;

    always begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            for (int d = 0; d < N_DST; d++) begin
                m_sh_src[d] = 0; m_sh_en[d] = 0; m_sh_inv[d] = 0;
                m_act_src[d] = 0; m_act_en[d] = 0; m_act_inv[d] = 0;
            end
            for (int i = 0; i < 4; i++) hist[i] = '0;
            m_left = 0; e_out = '0; e_oe = '0; e_err = 0;
        end else begin
            sv = (SYNC == 0) ? src_in : hist[SYNC-1];
            for (int i = 3; i > 0; i--) hist[i] = hist[i-1];
            hist[0] = src_in;
            busy_pre = (m_left > 0);
            for (int d = 0; d < N_DST; d++) begin
                e_oe[d]  = !busy_pre && m_act_en[d];
                e_out[d] = e_oe[d] && (sv[m_act_src[d]] ^ m_act_inv[d]);
            end
            e_err = 0;
            if (busy_pre) begin
                m_left--;
                if (m_left == 0) begin
                    m_act_src = m_sh_src; m_act_en = m_sh_en; m_act_inv = m_sh_inv;
                end
            end else begin
                if (bus.cfg_valid) begin
                    if (int'(bus.cfg_dst) >= N_DST || int'(bus.cfg_src) >= N_SRC) begin
                        e_err = 1;
                    end else begin
                        m_sh_src[bus.cfg_dst] = int'(bus.cfg_src);
                        m_sh_en[bus.cfg_dst]  = bus.cfg_en;
                        m_sh_inv[bus.cfg_dst] = bus.cfg_inv;
                    end
                end
                if (bus.commit) m_left = BBM + 1;
            end
        end
    end

    always begin
        @(negedge clk);
        if (cmp_on) begin
            chk("dst_out", dst_out, e_out);
            chk("dst_oe", dst_oe, e_oe);
            chk("busy", bus.busy, m_left > 0);
            chk("cfg_ready", bus.cfg_ready, m_left == 0);
            chk("cfg_err", bus.cfg_err, e_err);
        end
    end

    task automatic wr(input int d, input int s, input bit en, input bit inv);
        bus.cfg_valid = 1'b1;
        bus.cfg_dst   = DW'(d);
        bus.cfg_src   = SW'(s);
        bus.cfg_en    = en;
        bus.cfg_inv   = inv;
        @(negedge clk);
        bus.cfg_valid = 1'b0;
    endtask

    task automatic commit_pulse();
        bus.commit = 1'b1;
        @(negedge clk);
        bus.commit = 1'b0;
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (bus.busy && n < 50) begin
            @(negedge clk);
            n++;
        end
    endtask

    int n, low;
    bit early;

    initial begin
        bus.cfg_valid = 0; bus.cfg_dst = '0; bus.cfg_src = '0;
        bus.cfg_en = 0; bus.cfg_inv = 0; bus.commit = 0;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        cmp_on = 1'b1;
        chk("reset_oe", dst_oe, 0);
        chk("reset_out", dst_out, 0);
        chk("reset_busy", bus.busy, 0);
        chk("reset_ready", bus.cfg_ready, 1);

        src_in = '1;
        repeat (5) @(negedge clk);
        chk("idle_toggle", {dst_out, dst_oe}, 0);
        src_in = '0;
        repeat (2) @(negedge clk);

        // basic route dst5 <- src0
        wr(5, 0, 1, 0);
        commit_pulse();
        wait_idle(n);
        chk("busy_len", n, 5);
        @(negedge clk);
        chk("oe5_after_commit", dst_oe[5], 1);
        src_in[0] = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!dst_out[5] && n < 20);
        chk("latency", n, 3);

        // invert + fan-out
        src_in[7] = 1'b1;
        wr(2, 7, 1, 0);
        wr(3, 7, 1, 1);
        commit_pulse();
        wait_idle(n);
        repeat (2) @(negedge clk);
        chk("fanout_d2", dst_out[2], 1);
        chk("fanout_d3_inv", dst_out[3], 0);
        chk("fanout_d3_oe", dst_oe[3], 1);

        // break-before-make reroute dst5 src0 -> src1
        src_in[0] = 1'b0; src_in[1] = 1'b1;
        repeat (4) @(negedge clk);
        chk("bbm_pre", dst_out[5], 0);
        wr(5, 1, 1, 0);
        chk("shadow_only", dst_out[5], 0);
        commit_pulse();
        early = 0; n = 0;
        while (dst_oe[5] && n < 20) begin
            if (dst_out[5]) early = 1;
            @(negedge clk); n++;
        end
        low = 0;
        while (!dst_oe[5] && low < 20) begin
            @(negedge clk); low++;
        end
        chk("bbm_low_len", low, 5);
        chk("bbm_no_early", early, 0);
        chk("bbm_new_route", dst_out[5], 1);

        // rejected write
        wr(5, N_SRC, 1, 0);
        chk("err_pulse", bus.cfg_err, 1);
        @(negedge clk);
        chk("err_one_cycle", bus.cfg_err, 0);
        commit_pulse();
        wait_idle(n);
        repeat (2) @(negedge clk);
        chk("err_map_kept_oe", dst_oe[5], 1);
        chk("err_map_kept_out", dst_out[5], 1);

        // write while busy is dropped
        commit_pulse();
        chk("busy_not_ready", bus.cfg_ready, 0);
        wr(4, 9, 1, 0);
        wait_idle(n);
        commit_pulse();
        wait_idle(n);
        repeat (2) @(negedge clk);
        chk("busy_write_dropped", dst_oe[4], 0);

        // async reset in cycle 2 of BBM
        commit_pulse();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_oe", dst_oe, 0);
        chk("rst_mid_out", dst_out, 0);
        chk("rst_mid_busy", bus.busy, 0);
        chk("rst_mid_ready", bus.cfg_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_mid_cleared", dst_oe, 0);

        for (int it = 0; it < 3000; it++) begin
            src_in        = {$urandom, $urandom};
            bus.cfg_valid = ($urandom_range(0, 3) == 0);
            bus.cfg_dst   = DW'($urandom_range(0, 39));
            bus.cfg_src   = SW'($urandom_range(0, 39));
            bus.cfg_en    = ($urandom_range(0, 3) != 0);
            bus.cfg_inv   = $urandom_range(0, 1);
            bus.commit    = ($urandom_range(0, 15) == 0);
            rst_n         = ($urandom_range(0, 999) != 0);
            @(negedge clk);
        end
        rst_n = 1'b1;
        bus.cfg_valid = 0; bus.commit = 0;
        repeat (3) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
